regbank_writer: RTL

//  Write side of the 8x16 register bank. Owns the register array.
//  - Buffers destination-register writes (DR, value) from execute/load in a small in-order queue.
//  - Commits one queued write per cycle into the array.
//  - Serves the SR1/SR2 source-operand reads, registered.
//  - Sits between the execute stage (write producer) and the operand-fetch stage (SR1OUT/SR2OUT consumer).

---
 rtl/regbank_writer_if.sv | 32 +++
 rtl/regbank_writer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regbank_writer_if.sv
// Write-queue, operand-read and commit-status bundle for regbank_writer.
// The slave modport is the register bank side; master is the execute/operand-fetch side.
interface regbank_writer_if #(
  parameter int QDEPTH = 4,
  parameter int DWIDTH = 16
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic              wr_valid;
  logic              wr_ready;
  logic [2:0]        wr_dr;
  logic [DWIDTH-1:0] wr_data;
  logic              commit_hold;
  logic              flush;
  logic [2:0]        register1;
  logic [2:0]        register2;
  logic [DWIDTH-1:0] sr1out;
  logic [DWIDTH-1:0] sr2out;
  logic              commit_vld;
  logic [2:0]        commit_dr;
  logic [CW-1:0]     pending;

  modport master (
    output wr_valid, wr_dr, wr_data, commit_hold, flush, register1, register2,
    input  wr_ready, sr1out, sr2out, commit_vld, commit_dr, pending
  );

  modport slave (
    input  wr_valid, wr_dr, wr_data, commit_hold, flush, register1, register2,
    output wr_ready, sr1out, sr2out, commit_vld, commit_dr, pending
  );
endinterface

// File: rtl/regbank_writer.sv
// 8xDWIDTH register bank with an in-order write queue committing one entry per cycle.
// Optional REGBANK_WRITER_BYPASS_EN forwards queued writes onto the SR1/SR2 read ports.
module regbank_writer #(
  parameter int QDEPTH = 4,
  parameter int DWIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  regbank_writer_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_FLUSHING = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] array_q [8];
  logic [DWIDTH-1:0] array_d [8];
  logic [2:0]        q_dr_q [QDEPTH];
  logic [2:0]        q_dr_d [QDEPTH];
  logic [DWIDTH-1:0] q_data_q [QDEPTH];
  logic [DWIDTH-1:0] q_data_d [QDEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DWIDTH-1:0] sr1_q, sr1_d;
  logic [DWIDTH-1:0] sr2_q, sr2_d;
  logic              commit_vld_q, commit_vld_d;
  logic [2:0]        commit_dr_q, commit_dr_d;
  logic              wr_ready_s;
  logic              accept_s;
  logic              commit_s;
`ifdef REGBANK_WRITER_BYPASS_EN
  logic [PW-1:0]     fwd_idx_s;
`endif

  // A full queue refuses writes even when a commit frees a slot this cycle.
  assign wr_ready_s = (count_q != CW'(QDEPTH)) && !rst && (state_q != ST_FLUSHING);
  assign accept_s   = bus.wr_valid && wr_ready_s && !bus.flush;
  assign commit_s   = (state_q == ST_DRAIN) && !bus.commit_hold && !bus.flush
                      && (count_q != {CW{1'b0}});

  // Queue, array and FSM next-state; FLUSH outranks enqueue and commit.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    array_d      = array_q;
    q_dr_d       = q_dr_q;
    q_data_d     = q_data_q;
    commit_vld_d = 1'b0;
    commit_dr_d  = 3'd0;
    if (bus.flush) begin
      state_d = ST_FLUSHING;
      count_d = {CW{1'b0}};
      head_d  = tail_q;
    end else begin
      if (accept_s) begin
        q_dr_d[tail_q]   = bus.wr_dr;
        q_data_d[tail_q] = bus.wr_data;
        tail_d           = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (commit_s) begin
        array_d[q_dr_q[head_q]] = q_data_q[head_q];
        commit_vld_d            = 1'b1;
        commit_dr_d             = q_dr_q[head_q];
        head_d                  = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      count_d = count_q + {{(CW-1){1'b0}}, accept_s} - {{(CW-1){1'b0}}, commit_s};
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (count_d == {CW{1'b0}}) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_FLUSHING: state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Operand reads see the array before this cycle's commit.
  always_comb begin
    sr1_d = array_q[bus.register1];
    sr2_d = array_q[bus.register2];
`ifdef REGBANK_WRITER_BYPASS_EN
    fwd_idx_s = head_q;
    // Walk oldest to youngest so the youngest match wins; head is the committing entry.
    if (!bus.flush) begin
      for (int i = 0; i < QDEPTH; i++) begin
        fwd_idx_s = head_q + PW'(i);
        if (CW'(i) < count_q) begin
          if (q_dr_q[fwd_idx_s] == bus.register1) begin
            sr1_d = q_data_q[fwd_idx_s];
          end else begin
            sr1_d = sr1_d;
          end
          if (q_dr_q[fwd_idx_s] == bus.register2) begin
            sr2_d = q_data_q[fwd_idx_s];
          end else begin
            sr2_d = sr2_d;
          end
        end else begin
          sr1_d = sr1_d;
        end
      end
    end else begin
      sr1_d = array_q[bus.register1];
    end
`endif
  end

  // All state, including the register array, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      head_q       <= {PW{1'b0}};
      tail_q       <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
      sr1_q        <= {DWIDTH{1'b0}};
      sr2_q        <= {DWIDTH{1'b0}};
      commit_vld_q <= 1'b0;
      commit_dr_q  <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        array_q[i] <= {DWIDTH{1'b0}};
      end
      for (int i = 0; i < QDEPTH; i++) begin
        q_dr_q[i]   <= 3'd0;
        q_data_q[i] <= {DWIDTH{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      sr1_q        <= sr1_d;
      sr2_q        <= sr2_d;
      commit_vld_q <= commit_vld_d;
      commit_dr_q  <= commit_dr_d;
      array_q      <= array_d;
      q_dr_q       <= q_dr_d;
      q_data_q     <= q_data_d;
    end
  end

  assign bus.wr_ready   = wr_ready_s;
  assign bus.sr1out     = sr1_q;
  assign bus.sr2out     = sr2_q;
  assign bus.commit_vld = commit_vld_q;
  assign bus.commit_dr  = commit_dr_q;
  assign bus.pending    = count_q;
endmodule
